// File: rtl/cms_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cms_ctrl_pkg
// Shared definitions for the continuous-monitoring-system control-port arbiter:
//   - arb_state_e     : arbiter FSM state encoding (IDLE/SETUP/STROBE/GAP)
//   - CMS_ADDR_WIDTH / CMS_DATA_WIDTH : default control address / data widths
//   - CMS_ADDR_*      : monitor control register addresses
//   - cms_max()       : constant helper used for counter sizing
// -----------------------------------------------------------------------------
package cms_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_STROBE = 2'd2,
        ARB_GAP    = 2'd3
    } arb_state_e;

    localparam int unsigned CMS_ADDR_WIDTH = 8;
    localparam int unsigned CMS_DATA_WIDTH = 64;

    // Monitor control register map
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_TRACE_START_EN    = 8'd0;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_TRACE_END_EN      = 8'd1;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_TRACE_START_ADDR  = 8'd2;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_TRACE_END_ADDR    = 8'd3;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_RANGE_LOWER_EN    = 8'd4;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_RANGE_UPPER_EN    = 8'd5;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_RANGE_LOWER_BOUND = 8'd6;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_RANGE_UPPER_BOUND = 8'd7;
    localparam logic [CMS_ADDR_WIDTH-1:0] CMS_ADDR_WFI_STOP          = 8'd8;

    function automatic int unsigned cms_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cms_rr_picker.sv
// -----------------------------------------------------------------------------
// cms_rr_picker
// Pure combinational winner selection. Searches valid_i starting at ptr_i and
// wrapping around; the first asserted bit wins. With ptr_i tied to 0 this is a
// lowest-index fixed-priority picker.
//   valid_i [N]      : request bits
//   ptr_i   [IDW]    : first index to examine (must be < N)
//   grant_o [N]      : one-hot winner, all zero when nothing is valid
//   idx_o   [IDW]    : winner index, 0 when nothing is valid
//   any_o            : at least one request is valid
// -----------------------------------------------------------------------------
module cms_rr_picker #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    localparam logic [IDW:0] NUM = (IDW+1)'(N);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < int'(N); k++) begin
            // ptr_i < N and k < N, so a single subtraction performs the wrap.
            sum = {1'b0, ptr_i} + (IDW+1)'(k);
            if (sum >= NUM) begin
                sum = sum - NUM;
            end
            cand = sum[IDW-1:0];
            if (!found && valid_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) begin
            grant_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/cms_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// cms_ctrl_arbiter
// Shares the monitor's single control write port between NUM_REQ requesters.
// Each accepted request is replayed as SETUP (addr/data held, WE low),
// a one-cycle STROBE (WE high) and GAP (WE low), so both edge- and
// level-triggered write-enable modes of the monitor see exactly one write.
//
// Handshake: a transfer happens on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, one-hot on the
// picker's winner, and only ever asserted in IDLE. Requesters hold valid,
// addr and data stable until ready; dropping valid early withdraws the request.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake [NUM_REQ]
//   req_addr/wdata    : requester i at [i*W +: W]
//   ctrl_addr/wdata   : registered, change only on a transfer
//   ctrl_write_enable : registered strobe
//   busy              : state is not IDLE
//   grant_id          : index of the last accepted requester (registered)
//   dbg_state         : current FSM state (arb_state_e encoding)
//
// Build option: CMS_CTRL_ARB_FIXED_PRIO_EN selects lowest-index fixed priority
// (no pointer register); otherwise round-robin with the pointer moving to the
// index after each winner.
// -----------------------------------------------------------------------------
module cms_ctrl_arbiter
    import cms_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned ADDR_WIDTH   = CMS_ADDR_WIDTH,
    parameter  int unsigned DATA_WIDTH   = CMS_DATA_WIDTH,
    parameter  int unsigned SETUP_CYCLES = 1,
    parameter  int unsigned GAP_CYCLES   = 1,
    localparam int unsigned IDW          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [ADDR_WIDTH-1:0]            ctrl_addr,
    output logic [DATA_WIDTH-1:0]            ctrl_wdata,
    output logic                             ctrl_write_enable,
    output logic                             busy,
    output logic [IDW-1:0]                   grant_id,
    output logic [1:0]                       dbg_state
);

    localparam int unsigned CNT_W = $clog2(cms_max(SETUP_CYCLES, GAP_CYCLES) + 1);

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   we_q;
    logic [IDW-1:0]         gid_q;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;
    logic [IDW-1:0]         ptr;
    logic                   xfer;

`ifdef CMS_CTRL_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign ptr = ptr_q;
`endif

    cms_rr_picker #(.N(NUM_REQ)) u_picker (
        .valid_i (req_valid),
        .ptr_i   (ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign req_ready = (state_q == ARB_IDLE) ? pick_grant : '0;
    assign xfer      = (state_q == ARB_IDLE) && pick_any;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            ARB_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ARB_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_STROBE: begin
                state_d = ARB_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            ARB_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Registering WE from the next state keeps it aligned with STROBE.
            we_q    <= (state_d == ARB_STROBE);
            if (xfer) begin
                addr_q  <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                gid_q   <= pick_idx;
            end
        end
    end

    assign ctrl_addr         = addr_q;
    assign ctrl_wdata        = wdata_q;
    assign ctrl_write_enable = we_q;
    assign busy              = (state_q != ARB_IDLE);
    assign grant_id          = gid_q;
    assign dbg_state         = state_q;

endmodule
